conv_sweep_ctrl: RTL

Control FSM that drives one PE datapath through a full 4×4-kernel convolution sweep of an IMG_SIZE×IMG_SIZE image.

- Generates the window base index, kernel-tap counter, and MAC accumulate/clear strobes.
- Packs four byte results into one 32-bit memory word.
- Issues memory writes and a final file dump.
- Sits directly upstream of the PE datapath; its outputs connect one-to-one to the datapath's same-named control inputs.

---
 rtl/conv_pkg.sv | 19 +
 rtl/window_addr_gen.sv | 58 +++++
 rtl/conv_sweep_ctrl.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution sweep controller.
package conv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    MAC,
    STORE,
    WRITE,
    CLRRES,
    FILE,
    DONE
  } state_e;

  localparam int unsigned KERNEL         = 4;
  localparam int unsigned TAPS           = 16;
  localparam int unsigned BYTES_PER_WORD = 4;

endpackage

// File: rtl/window_addr_gen.sv
// Row-major window walker: tracks row/col, flags the last window and
// produces the registered window base index row*IMG_SIZE + col.
module window_addr_gen
  import conv_pkg::*;
#(
  parameter int unsigned IMG_SIZE = 16,
  parameter int unsigned STRIDE   = 1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clr_i,
  input  logic       adv_i,
  output logic [7:0] idx_o,
  output logic       last_o
);

  localparam logic [7:0] LastPos = 8'(IMG_SIZE - KERNEL);
  localparam logic [7:0] Step    = 8'(STRIDE);
  localparam logic [7:0] Width   = 8'(IMG_SIZE);

  logic [7:0] row_q, row_d;
  logic [7:0] col_q, col_d;
  logic [7:0] idx_q, idx_d;

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clr_i) begin
      row_d = '0;
      col_d = '0;
    end else if (adv_i) begin
      if (col_q == LastPos) begin
        col_d = '0;
        row_d = row_q + Step;
      end else begin
        col_d = col_q + Step;
      end
    end
    // Index is registered alongside row/col so it is stable for the whole window.
    idx_d = 8'(row_d * Width) + col_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      row_q <= '0;
      col_q <= '0;
      idx_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
      idx_q <= idx_d;
    end
  end

  assign idx_o  = idx_q;
  assign last_o = (row_q == LastPos) && (col_q == LastPos);

endmodule

// File: rtl/conv_sweep_ctrl.sv
// Control FSM sequencing one PE datapath through a full 4x4-kernel sweep,
// packing four byte results per memory word and finishing with a file dump.
module conv_sweep_ctrl
  import conv_pkg::*;
#(
  parameter int unsigned IMG_SIZE     = 16,
  parameter int unsigned STRIDE       = 1,
  parameter int unsigned MAX_MEM_SIZE = 128
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       rst_acc,
  output logic       acc_en,
  output logic       res_buffer_en,
  output logic       rst_res_reg,
  output logic       wr_en,
  output logic       wr_file,
  output logic [7:0] img_buffer_index,
  output logic [7:0] buffer_cntr,
  output logic [7:0] res_index,
  output logic [7:0] wr_adr
);

  localparam logic [7:0] TapLast  = 8'(TAPS - 1);
  localparam logic [7:0] SlotLast = 8'(BYTES_PER_WORD - 1);
  localparam logic [7:0] MemLast  = 8'(MAX_MEM_SIZE - 1);

  state_e     state_q, state_d;
  logic [7:0] tap_q, tap_d;
  logic [7:0] res_index_q, res_index_d;
  logic [7:0] wr_adr_q, wr_adr_d;
  logic       win_clr, win_adv, win_last;

  logic busy_q, busy_d;
  logic done_q, done_d;
  logic rst_acc_q, rst_acc_d;
  logic acc_en_q, acc_en_d;
  logic res_buffer_en_q, res_buffer_en_d;
  logic rst_res_reg_q, rst_res_reg_d;
  logic wr_en_q, wr_en_d;
  logic wr_file_q, wr_file_d;

  window_addr_gen #(
    .IMG_SIZE (IMG_SIZE),
    .STRIDE   (STRIDE)
  ) u_window_addr_gen (
    .clk_i  (clk),
    .rst_ni (rst),
    .clr_i  (win_clr),
    .adv_i  (win_adv),
    .idx_o  (img_buffer_index),
    .last_o (win_last)
  );

  always_comb begin
    state_d     = state_q;
    tap_d       = tap_q;
    res_index_d = res_index_q;
    wr_adr_d    = wr_adr_q;
    win_clr     = 1'b0;
    win_adv     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = INIT;
      end
      INIT: begin
        win_clr     = 1'b1;
        tap_d       = '0;
        res_index_d = '0;
        wr_adr_d    = '0;
        state_d     = MAC;
      end
      MAC: begin
        if (tap_q == TapLast) begin
          tap_d   = '0;
          state_d = STORE;
        end else begin
          tap_d = tap_q + 8'd1;
        end
      end
      STORE: begin
        res_index_d = (res_index_q == SlotLast) ? 8'd0 : res_index_q + 8'd1;
        if ((res_index_q == SlotLast) || win_last) begin
          state_d = WRITE;
        end else begin
          win_adv = 1'b1;
          state_d = MAC;
        end
      end
      WRITE: begin
        state_d = CLRRES;
      end
      CLRRES: begin
        if (win_last) begin
          state_d = FILE;
        end else begin
          win_adv = 1'b1;
          state_d = MAC;
          // Saturate rather than wrap past the end of the datapath memory.
          if (wr_adr_q < MemLast) wr_adr_d = wr_adr_q + 8'd1;
        end
      end
      FILE: begin
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Strobes are decoded from the next state so every output comes straight from a flop.
  always_comb begin
    busy_d          = (state_d != IDLE);
    done_d          = (state_d == DONE);
    rst_acc_d       = (state_d == INIT) || (state_d == STORE);
    acc_en_d        = (state_d == MAC);
    res_buffer_en_d = (state_d == STORE);
    rst_res_reg_d   = (state_d == INIT) || (state_d == CLRRES);
    wr_en_d         = (state_d == WRITE);
    wr_file_d       = (state_d == FILE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= IDLE;
      tap_q           <= '0;
      res_index_q     <= '0;
      wr_adr_q        <= '0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      rst_acc_q       <= 1'b0;
      acc_en_q        <= 1'b0;
      res_buffer_en_q <= 1'b0;
      rst_res_reg_q   <= 1'b0;
      wr_en_q         <= 1'b0;
      wr_file_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      tap_q           <= tap_d;
      res_index_q     <= res_index_d;
      wr_adr_q        <= wr_adr_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      rst_acc_q       <= rst_acc_d;
      acc_en_q        <= acc_en_d;
      res_buffer_en_q <= res_buffer_en_d;
      rst_res_reg_q   <= rst_res_reg_d;
      wr_en_q         <= wr_en_d;
      wr_file_q       <= wr_file_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign rst_acc       = rst_acc_q;
  assign acc_en        = acc_en_q;
  assign res_buffer_en = res_buffer_en_q;
  assign rst_res_reg   = rst_res_reg_q;
  assign wr_en         = wr_en_q;
  assign wr_file       = wr_file_q;
  assign buffer_cntr   = tap_q;
  assign res_index     = res_index_q;
  assign wr_adr        = wr_adr_q;

endmodule
